ex_mem_latch: RTL and testbench

Pipeline register and request controller between the execute stage and the memory stage. It captures one execute-stage result per cycle and presents it to the memory stage. For loads and stores it holds the cache request until the memory system reports `Done`, and back-pressures earlier stages meanwhile. It also detects halt, memory errors and request timeouts, and freezes the pipeline on any of them.

---
 rtl/ex_mem_latch.sv | 84 ++++++++
 tb/tb_ex_mem_latch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline register with cache request hold, stall, halt and error detection
module ex_mem_latch #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exValid,
  input  logic [15:0] exAluOut,
  input  logic [15:0] exWrData,
  input  logic        exMemRead,
  input  logic        exMemWrite,
  input  logic        exHalt,
  input  logic        exLbi,
  input  logic        exRegWrite,
  input  logic [2:0]  exWrReg,
  input  logic        memDone,
  input  logic        memStall,
  input  logic        memErr,
  output logic [15:0] aluOut,
  output logic [15:0] wrData,
  output logic        memRead,
  output logic        memWrite,
  output logic        halt,
  output logic        lbi,
  output logic        regWrite,
  output logic [2:0]  wrReg,
  output logic        retire,
  output logic        stallUp,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY, HALTED} stateT;
  stateT state, nextState;
  logic valid, rdQ, wrQ, exMemOp, timeout, unusedStall;
  logic [7:0] waitCnt;
  assign unusedStall = memStall;
  always_comb begin
    exMemOp = exValid & !exLbi & (exMemRead | exMemWrite);
    timeout = state == BUSY & !memDone & waitCnt == 8'(TIMEOUT - 1);
    retire = state == IDLE ? valid : state == BUSY ? (memDone | memErr) : 1'b0;
    stallUp = state == HALTED | (state == BUSY & (!memDone | memErr));
    memRead = rdQ & state != HALTED;
    memWrite = wrQ & state != HALTED;
    // memErr and timeout take precedence over a simultaneous completion
    nextState = state == HALTED ? HALTED :
                state == IDLE ? (valid & halt ? HALTED : exMemOp ? BUSY : IDLE) :
                (memErr | timeout) ? HALTED :
                !memDone ? BUSY :
                halt ? HALTED :
                exMemOp ? BUSY : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      rdQ <= 1'b0;
      wrQ <= 1'b0;
      halt <= 1'b0;
      lbi <= 1'b0;
      regWrite <= 1'b0;
      wrReg <= '0;
      aluOut <= '0;
      wrData <= '0;
      waitCnt <= '0;
      err <= 1'b0;
    end else begin
      state <= nextState;
      if (!stallUp) begin
        valid <= exValid;
        rdQ <= exValid & exMemRead & !exLbi;
        wrQ <= exValid & exMemWrite & !exLbi;
        halt <= exValid & exHalt;
        lbi <= exValid & exLbi;
        regWrite <= exValid & exRegWrite;
        wrReg <= exValid ? exWrReg : 3'd0;
        if (exValid) begin
          aluOut <= exAluOut;
          wrData <= exWrData;
        end
      end
      waitCnt <= (state == BUSY & !memDone) ? (waitCnt == 8'hFF ? waitCnt : waitCnt + 8'd1) : 8'd0;
      if (state == BUSY & (memErr | timeout)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ex_mem_latch.sv
// tb_ex_mem_latch: directed vectors for the EX/MEM latch with a short timeout
module tb_ex_mem_latch;
  logic clk = 0, rst = 1;
  logic exValid, exMemRead, exMemWrite, exHalt, exLbi, exRegWrite;
  logic [15:0] exAluOut, exWrData;
  logic [2:0] exWrReg;
  logic memDone, memStall, memErr;
  logic [15:0] aluOut, wrData;
  logic memRead, memWrite, halt, lbi, regWrite, retire, stallUp, err;
  logic [2:0] wrReg;
  int checks = 0, errors = 0;

  ex_mem_latch #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .exValid(exValid), .exAluOut(exAluOut), .exWrData(exWrData),
    .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exHalt(exHalt), .exLbi(exLbi),
    .exRegWrite(exRegWrite), .exWrReg(exWrReg), .memDone(memDone), .memStall(memStall),
    .memErr(memErr), .aluOut(aluOut), .wrData(wrData), .memRead(memRead), .memWrite(memWrite),
    .halt(halt), .lbi(lbi), .regWrite(regWrite), .wrReg(wrReg), .retire(retire),
    .stallUp(stallUp), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [15:0] a, input logic [15:0] d,
                     input logic rd, input logic wr, input logic h, input logic l);
    exValid = v; exAluOut = a; exWrData = d; exMemRead = rd; exMemWrite = wr;
    exHalt = h; exLbi = l; exRegWrite = v; exWrReg = 3'd5;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    memDone = 0; memStall = 0; memErr = 0;
    drv(0, 0, 0, 0, 0, 0, 0);
    tick; settle;
    chk("rst_memRead", memRead, 0);
    chk("rst_memWrite", memWrite, 0);
    chk("rst_retire", retire, 0);
    chk("rst_stallUp", stallUp, 0);
    chk("rst_err", err, 0);
    chk("rst_aluOut", aluOut, 0);
    rst = 0;
    // four back-to-back ALU ops
    drv(1, 16'd1, 0, 0, 0, 0, 0);
    tick;
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) drv(1, 16'(i + 1), 0, 0, 0, 0, 0);
      else drv(0, 16'hFFFF, 0, 0, 0, 0, 0);
      settle;
      chk("alu_retire", retire, 1);
      chk("alu_aluOut", aluOut, i);
      chk("alu_stallUp", stallUp, 0);
      tick;
    end
    settle;
    chk("bubble_retire", retire, 0);
    chk("bubble_aluOut", aluOut, 4);
    chk("bubble_regWrite", regWrite, 0);
    // load hit
    drv(1, 16'h0040, 0, 1, 0, 0, 0);
    tick;
    memDone = 1;
    drv(1, 16'h0055, 0, 0, 0, 0, 0);
    settle;
    chk("hit_memRead", memRead, 1);
    chk("hit_retire", retire, 1);
    chk("hit_stallUp", stallUp, 0);
    chk("hit_aluOut", aluOut, 16'h0040);
    tick;
    memDone = 0;
    drv(1, 16'h0080, 16'hBEEF, 0, 1, 0, 0);
    settle;
    chk("next_aluOut", aluOut, 16'h0055);
    chk("next_memRead", memRead, 0);
    chk("next_retire", retire, 1);
    tick;
    // store miss: done arrives on the 5th busy cycle
    drv(1, 16'h0099, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      settle;
      chk("miss_stallUp", stallUp, 1);
      chk("miss_retire", retire, 0);
      chk("miss_memWrite", memWrite, 1);
      chk("miss_aluOut", aluOut, 16'h0080);
      chk("miss_wrData", wrData, 16'hBEEF);
      tick;
    end
    memDone = 1;
    settle;
    chk("miss_done_retire", retire, 1);
    chk("miss_done_stallUp", stallUp, 0);
    tick;
    memDone = 0;
    drv(1, 16'h0012, 0, 1, 0, 0, 1);
    settle;
    chk("after_miss_aluOut", aluOut, 16'h0099);
    chk("after_miss_memWrite", memWrite, 0);
    chk("after_miss_retire", retire, 1);
    tick;
    // lbi suppresses the read and stays in IDLE
    drv(0, 0, 0, 0, 0, 0, 0);
    settle;
    chk("lbi_memRead", memRead, 0);
    chk("lbi_flag", lbi, 1);
    chk("lbi_retire", retire, 1);
    chk("lbi_stallUp", stallUp, 0);
    tick;
    settle;
    chk("lbi_idle_stallUp", stallUp, 0);
    chk("lbi_idle_retire", retire, 0);
    // load followed by halt
    drv(1, 16'h0020, 0, 1, 0, 0, 0);
    tick;
    drv(1, 16'h0001, 0, 0, 0, 1, 0);
    settle;
    chk("hl_wait_stallUp", stallUp, 1);
    chk("hl_wait_retire", retire, 0);
    tick;
    memDone = 1;
    settle;
    chk("hl_done_retire", retire, 1);
    chk("hl_done_memRead", memRead, 1);
    tick;
    memDone = 0;
    drv(1, 16'h0077, 0, 0, 0, 0, 0);
    settle;
    chk("halt_flag", halt, 1);
    chk("halt_retire", retire, 1);
    chk("halt_stallUp", stallUp, 0);
    tick;
    drv(1, 16'h0033, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      settle;
      chk("halted_stallUp", stallUp, 1);
      chk("halted_retire", retire, 0);
      chk("halted_memRead", memRead, 0);
      tick;
    end
    chk("halted_err", err, 0);
    rst = 1;
    drv(0, 0, 0, 0, 0, 0, 0);
    tick;
    rst = 0;
    drv(1, 16'h0044, 0, 0, 0, 0, 0);
    settle;
    chk("unhalt_stallUp", stallUp, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    settle;
    chk("unhalt_retire", retire, 1);
    chk("unhalt_aluOut", aluOut, 16'h0044);
    tick;
    // timeout with memDone never asserted
    drv(1, 16'h0030, 0, 1, 0, 0, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      settle;
      chk("to_wait_err", err, 0);
      chk("to_wait_memRead", memRead, 1);
      tick;
    end
    settle;
    chk("to_err", err, 1);
    chk("to_memRead", memRead, 0);
    chk("to_stallUp", stallUp, 1);
    chk("to_retire", retire, 0);
    // reset mid-request abandons it
    rst = 1;
    tick;
    rst = 0;
    drv(1, 16'h0050, 0, 1, 0, 0, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    settle;
    chk("pre_rst_memRead", memRead, 1);
    chk("rst_clears_err", err, 0);
    rst = 1;
    tick;
    rst = 0;
    settle;
    chk("mid_rst_memRead", memRead, 0);
    chk("mid_rst_stallUp", stallUp, 0);
    // memErr in BUSY
    drv(1, 16'h0060, 0, 0, 1, 0, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    memErr = 1;
    settle;
    chk("merr_retire", retire, 1);
    chk("merr_stallUp", stallUp, 1);
    tick;
    memErr = 0;
    settle;
    chk("merr_err", err, 1);
    chk("merr_memWrite", memWrite, 0);
    chk("merr_halted_stall", stallUp, 1);
    tick;
    tick;
    settle;
    chk("merr_sticky", err, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
